fp_decode_stage: RTL and testbench
==================================

Name: fp_decode_stage

Overview:
- Registered, parametrised successor to the combinational FP decoder; sits between the core's instruction issue and the FPU/FP register file.
- Decodes RV F (and optionally D) instructions: loads/stores, fused multiply-add, OP-FP arithmetic/sign-injection/min-max/compare/classify/convert/move.
- Resolves dynamic rounding mode against frm_i and flags illegal encodings.
- Delivers a decoded bundle through a valid/ready interface backed by a 2-entry skid buffer; generalises the FMV hold pulse into a programmable busy window.

Parameters:
- ENABLE_D, 1'b1, accept double-precision encodings (fmt=01, FLD/FSD, FCVT.S.D/FCVT.D.S); when 0 these are illegal.
- MOVE_HOLD, 3, cycles move_busy_o stays high after an FMV.X.W/FMV.W.X is accepted; range 1..15.
- BUF_DEPTH, 2, output buffer entries; only 2 is supported (skid).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  discard buffered entries and the busy window
- instr_valid_i  in  1  instruction offered
- instr_ready_o  out  1  stage can accept
- instr_i  in  32  raw instruction
- frm_i  in  3  fcsr.frm for dynamic rounding
- dec_valid_o  out  1  decoded bundle valid
- dec_ready_i  in  1  consumer accepts bundle
- dec_op_o  out  4  fpnew_pkg::operation_e
- dec_op_mod_o  out  1  operation modifier
- dec_src_fmt_o / dec_dst_fmt_o  out  3 each  fpnew_pkg::fp_format_e
- dec_rm_o  out  3  resolved rounding mode (never 111)
- dec_rs1_o / dec_rs2_o / dec_rs3_o / dec_rd_o  out  5 each  register addresses
- dec_fp_wb_o  out  1  writes FP register file
- dec_int_wb_o  out  1  writes integer register file
- dec_load_o / dec_store_o  out  1 each  FP load/store
- dec_move_xs_o / dec_move_sx_o  out  1 each  FMV.X.W / FMV.W.X
- dec_fpu_o  out  1  needs FPU issue
- dec_illegal_o  out  1  illegal encoding
- move_busy_o  out  1  move hold window active

Behaviour:
- Reset: buffer empty; all dec_* outputs 0 (op=FMADD, fmts=FP32, rm=RNE); instr_ready_o=1; move_busy_o=0; hold counter 0.
- Accept when instr_valid_i && instr_ready_o. instr_ready_o = buffer not full, so it stays high with one entry buffered.
- Latency: bundle visible on dec_* one cycle after accept. Bundle is held stable while dec_valid_o && !dec_ready_i. Order is FIFO.
- Simultaneous accept and pop on a full buffer: pop first, accept allowed; ready is computed combinationally from the pop.
- flush_i (wins over accept in the same cycle): buffer emptied, move_busy_o cleared, counter 0 next cycle.
- Decode, opcode instr[6:0]:
  - 07/27, width 010: FP32 load/store; width 011: FP64 if ENABLE_D, else illegal. Loads set fp_wb; stores set none.
  - 43 / 47 / 4B / 4F: FMADD mod0 / FMADD mod1 / FNMSUB mod0 / FNMSUB mod1. fp_wb=1. fmt instr[26:25]: 00=S, 01=D (ENABLE_D), else illegal.
  - 53, funct7[6:2] with fmt in [1:0]:
    - ADD (00000), SUB = ADD mod1 (00001), MUL (00010), DIV (00011).
    - SQRT (01011, rs2 must be 0).
    - SGNJ (00100, rm<=010); MINMAX (00101, rm<=001).
    - CMP (10100, rm<=010; int_wb).
    - F2I (11000, rs2[4:1]=0, mod=rs2[0]; int_wb).
    - I2F (11010, same rs2 rule; fp_wb).
    - F2F (01000, S<->D; src fmt from rs2[1:0], dst from fmt; legal only with ENABLE_D).
    - 11100: rm 000 = FMV.X.W, S only, int_wb, move_xs, dec_fpu_o=0; rm 001 = CLASSIFY, int_wb.
    - 11110: rm 000, rs2 0 = FMV.W.X, S only, fp_wb, move_sx.
    - Anything else is illegal.
- Rounding: applies to arithmetic, fused, and conversion ops. rm 101/110 is illegal. rm 111 substitutes frm_i; frm_i >= 101 is then illegal. Non-rm ops pass instr[14:12] as recorded.
- Illegal instructions are still buffered: dec_illegal_o=1; fp_wb/int_wb/load/store/move/fpu all 0; addresses passed through.
- Move window: on accept of FMV.X.W or FMV.W.X, counter loads MOVE_HOLD and move_busy_o=1 from the next cycle. It decrements each cycle and deasserts when the counter reaches 0. A new move during the window reloads the counter.

Optional Feature:
- FP_DECODE_PERF_EN defined: adds outputs perf_decoded_o[31:0] and perf_illegal_o[31:0]. These count accepted instructions and accepted illegal ones. They saturate at 32'hFFFFFFFF, reset to 0, and are unaffected by flush_i.
- Undefined: ports and counters absent.

Test Plan:
- FADD.S x3,x1,x2 rm=000 (0x002081D3), dec_ready_i=1 -> next cycle: dec_valid_o=1, op=ADD, mod=0, fmt FP32, rs1=1, rs2=2, rd=3, fp_wb=1, illegal=0.
- FMUL.D rm=111 with frm_i=001 -> rm=001, fmt FP64. Same with frm_i=101 -> dec_illegal_o=1, fp_wb=0. With ENABLE_D=0 -> illegal.
- Back-pressure: dec_ready_i=0, three valid instrs -> first two accepted, instr_ready_o=0 on third. Raise dec_ready_i -> outputs in order, third accepted the same cycle the first pops.
- FMV.X.W (0xE0008553) accepted, MOVE_HOLD=3 -> move_busy_o high cycles 1-3 after accept. Second FMV at cycle 2 extends to cycle 5. flush_i clears it immediately.
- FNMADD.S (opcode 4F) -> op=FNMSUB, mod=1. FSQRT.S with rs2=1 -> illegal. FSGNJ with rm=011 -> illegal.
- Reset asserted with two entries buffered -> next cycle dec_valid_o=0, instr_ready_o=1. With FP_DECODE_PERF_EN, counters read 0.

Source files
------------

// File: rtl/fp_decode_stage.sv
// Registered RV F/D instruction decoder with a 2-entry skid buffer and an FMV busy window.
// Optional: define FP_DECODE_PERF_EN to add saturating decoded/illegal instruction counters.
module fp_decode_stage #(
  parameter logic        ENABLE_D  = 1'b1,
  parameter int unsigned MOVE_HOLD = 3,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [31:0] instr_i,
  input  logic [2:0]  frm_i,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output logic [3:0]  dec_op_o,
  output logic        dec_op_mod_o,
  output logic [2:0]  dec_src_fmt_o,
  output logic [2:0]  dec_dst_fmt_o,
  output logic [2:0]  dec_rm_o,
  output logic [4:0]  dec_rs1_o,
  output logic [4:0]  dec_rs2_o,
  output logic [4:0]  dec_rs3_o,
  output logic [4:0]  dec_rd_o,
  output logic        dec_fp_wb_o,
  output logic        dec_int_wb_o,
  output logic        dec_load_o,
  output logic        dec_store_o,
  output logic        dec_move_xs_o,
  output logic        dec_move_sx_o,
  output logic        dec_fpu_o,
  output logic        dec_illegal_o,
  output logic        move_busy_o
`ifdef FP_DECODE_PERF_EN
  ,
  output logic [31:0] perf_decoded_o,
  output logic [31:0] perf_illegal_o
`endif
);

  localparam logic [3:0] OP_FMADD = 4'd0, OP_FNMSUB = 4'd1, OP_ADD = 4'd2, OP_MUL = 4'd3,
                         OP_DIV = 4'd4, OP_SQRT = 4'd5, OP_SGNJ = 4'd6, OP_MINMAX = 4'd7,
                         OP_CMP = 4'd8, OP_CLASSIFY = 4'd9, OP_F2F = 4'd10, OP_F2I = 4'd11,
                         OP_I2F = 4'd12;
  localparam logic [2:0] FMT_FP32 = 3'd0, FMT_FP64 = 3'd1;
  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  typedef struct packed {
    logic [3:0] op;
    logic       op_mod;
    logic [2:0] src_fmt;
    logic [2:0] dst_fmt;
    logic [2:0] rm;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rs3;
    logic [4:0] rd;
    logic       fp_wb;
    logic       int_wb;
    logic       load;
    logic       store;
    logic       move_xs;
    logic       move_sx;
    logic       fpu;
    logic       illegal;
  } dec_t;

  logic [6:0] opc;
  logic [4:0] f5, rs2;
  logic [1:0] fmt;
  logic [2:0] rm_f, fmt_e;
  logic       fmt_ok, use_rm, ill;
  dec_t       d;

  always_comb begin
    opc    = instr_i[6:0];
    f5     = instr_i[31:27];
    fmt    = instr_i[26:25];
    rs2    = instr_i[24:20];
    rm_f   = instr_i[14:12];
    fmt_ok = (fmt == 2'b00) || ((fmt == 2'b01) && ENABLE_D);
    fmt_e  = (fmt == 2'b01) ? FMT_FP64 : FMT_FP32;
    use_rm = 1'b0;
    ill    = 1'b0;
    d         = '0;
    d.src_fmt = fmt_e;
    d.dst_fmt = fmt_e;
    d.rm      = rm_f;
    d.rs1     = instr_i[19:15];
    d.rs2     = rs2;
    d.rs3     = f5;
    d.rd      = instr_i[11:7];
    case (opc)
      7'h07, 7'h27: begin
        d.load  = (opc == 7'h07);
        d.store = (opc == 7'h27);
        d.fp_wb = (opc == 7'h07);
        if (rm_f == 3'b010) begin
          d.src_fmt = FMT_FP32;
          d.dst_fmt = FMT_FP32;
        end else if ((rm_f == 3'b011) && ENABLE_D) begin
          d.src_fmt = FMT_FP64;
          d.dst_fmt = FMT_FP64;
        end else ill = 1'b1;
      end
      7'h43, 7'h47, 7'h4B, 7'h4F: begin
        d.op     = opc[3] ? OP_FNMSUB : OP_FMADD;
        d.op_mod = opc[2];
        d.fp_wb  = 1'b1;
        d.fpu    = 1'b1;
        use_rm   = 1'b1;
        ill      = !fmt_ok;
      end
      7'h53: begin
        d.fpu = 1'b1;
        ill   = !fmt_ok;
        case (f5)
          5'b00000, 5'b00001: begin d.op = OP_ADD; d.op_mod = f5[0]; d.fp_wb = 1'b1; use_rm = 1'b1; end
          5'b00010, 5'b00011: begin d.op = f5[0] ? OP_DIV : OP_MUL; d.fp_wb = 1'b1; use_rm = 1'b1; end
          5'b01011: begin d.op = OP_SQRT; d.fp_wb = 1'b1; use_rm = 1'b1; ill = ill || (rs2 != 5'd0); end
          5'b00100: begin d.op = OP_SGNJ; d.fp_wb = 1'b1; ill = ill || (rm_f > 3'b010); end
          5'b00101: begin d.op = OP_MINMAX; d.fp_wb = 1'b1; ill = ill || (rm_f > 3'b001); end
          5'b10100: begin d.op = OP_CMP; d.int_wb = 1'b1; ill = ill || (rm_f > 3'b010); end
          5'b11000, 5'b11010: begin
            d.op     = f5[1] ? OP_I2F : OP_F2I;
            d.op_mod = rs2[0];
            d.fp_wb  = f5[1];
            d.int_wb = !f5[1];
            use_rm   = 1'b1;
            ill      = ill || (rs2[4:1] != 4'd0);
          end
          5'b01000: begin
            // Only S<->D conversions exist, so source and destination must differ
            d.op      = OP_F2F;
            d.src_fmt = rs2[0] ? FMT_FP64 : FMT_FP32;
            d.fp_wb   = 1'b1;
            use_rm    = 1'b1;
            ill       = ill || !ENABLE_D || (rs2[4:1] != 4'd0) || (rs2[0] == fmt[0]);
          end
          5'b11100: begin
            d.int_wb = 1'b1;
            if (rm_f == 3'b000) begin
              d.op      = OP_SGNJ;
              d.move_xs = 1'b1;
              d.fpu     = 1'b0;
              ill       = ill || (fmt != 2'b00);
            end else if (rm_f == 3'b001) d.op = OP_CLASSIFY;
            else ill = 1'b1;
          end
          5'b11110: begin
            d.op      = OP_SGNJ;
            d.fp_wb   = 1'b1;
            d.move_sx = 1'b1;
            ill       = ill || (rm_f != 3'b000) || (rs2 != 5'd0) || (fmt != 2'b00);
          end
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    if (use_rm) begin
      if ((rm_f == 3'b101) || (rm_f == 3'b110)) ill = 1'b1;
      else if (rm_f == 3'b111) begin
        d.rm = frm_i;
        if (frm_i >= 3'b101) ill = 1'b1;
      end
    end
    if (d.rm == 3'b111) d.rm = 3'b000;
    if (ill) begin
      {d.fp_wb, d.int_wb, d.load, d.store, d.move_xs, d.move_sx, d.fpu} = '0;
      d.illegal = 1'b1;
    end
  end

  dec_t             mem [BUF_DEPTH];
  dec_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       hold;
  logic             push, pop;

  assign dec_valid_o   = (cnt != '0);
  assign pop           = dec_valid_o && dec_ready_i;
  // A pop frees a slot in the same cycle, so a full buffer still accepts
  assign instr_ready_o = (cnt != CNT_W'(BUF_DEPTH)) || pop;
  assign push          = instr_valid_i && instr_ready_o && !flush_i;
  assign move_busy_o   = (hold != 4'd0);

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      hold   <= 4'd0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
      if (push && (d.move_xs || d.move_sx)) hold <= 4'(MOVE_HOLD);
      else if (hold != 4'd0)                hold <= hold - 4'd1;
    end
  end

  always_comb begin
    head = dec_valid_o ? mem[rd_ptr] : '0;
  end

  assign dec_op_o      = head.op;
  assign dec_op_mod_o  = head.op_mod;
  assign dec_src_fmt_o = head.src_fmt;
  assign dec_dst_fmt_o = head.dst_fmt;
  assign dec_rm_o      = head.rm;
  assign dec_rs1_o     = head.rs1;
  assign dec_rs2_o     = head.rs2;
  assign dec_rs3_o     = head.rs3;
  assign dec_rd_o      = head.rd;
  assign dec_fp_wb_o   = head.fp_wb;
  assign dec_int_wb_o  = head.int_wb;
  assign dec_load_o    = head.load;
  assign dec_store_o   = head.store;
  assign dec_move_xs_o = head.move_xs;
  assign dec_move_sx_o = head.move_sx;
  assign dec_fpu_o     = head.fpu;
  assign dec_illegal_o = head.illegal;

`ifdef FP_DECODE_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_decoded_o <= '0;
      perf_illegal_o <= '0;
    end else if (push) begin
      if (perf_decoded_o != '1)             perf_decoded_o <= perf_decoded_o + 32'd1;
      if (d.illegal && perf_illegal_o != '1) perf_illegal_o <= perf_illegal_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_decode_stage.sv
// Scoreboard bench for fp_decode_stage: directed vectors, expected bundles queued on accept.
module tb_fp_decode_stage;

  typedef struct packed {
    logic [41:0] b;
    logic        chk;
    logic        nod;
  } exp_t;

  logic        clk = 1'b0, rst_i = 1'b1, flush_i = 1'b0;
  logic        instr_valid_i = 1'b0, dec_ready_i = 1'b0;
  logic [31:0] instr_i = '0;
  logic [2:0]  frm_i = '0;
  logic        instr_ready_o, dec_valid_o, move_busy_o;
  logic [3:0]  dec_op_o;
  logic        dec_op_mod_o;
  logic [2:0]  dec_src_fmt_o, dec_dst_fmt_o, dec_rm_o;
  logic [4:0]  dec_rs1_o, dec_rs2_o, dec_rs3_o, dec_rd_o;
  logic        dec_fp_wb_o, dec_int_wb_o, dec_load_o, dec_store_o;
  logic        dec_move_xs_o, dec_move_sx_o, dec_fpu_o, dec_illegal_o;
  logic        n_ready, n_valid, n_busy, n_mod, n_fpwb, n_intwb, n_ld, n_st, n_mxs, n_msx, n_fpu, n_ill;
  logic [3:0]  n_op;
  logic [2:0]  n_sf, n_df, n_rm;
  logic [4:0]  n_rs1, n_rs2, n_rs3, n_rd;
`ifdef FP_DECODE_PERF_EN
  logic [31:0] perf_decoded_o, perf_illegal_o, n_pd, n_pi;
`endif

  int checks = 0, errors = 0;
  exp_t exp_q[$];
  exp_t me;
  logic [31:0] v_ins [16];
  logic [2:0]  v_frm [16];
  exp_t        v_exp [16];

  always #5 clk = ~clk;

  fp_decode_stage #(.ENABLE_D(1'b1), .MOVE_HOLD(3), .BUF_DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o), .instr_i(instr_i), .frm_i(frm_i), .dec_valid_o(dec_valid_o),
    .dec_ready_i(dec_ready_i), .dec_op_o(dec_op_o), .dec_op_mod_o(dec_op_mod_o),
    .dec_src_fmt_o(dec_src_fmt_o), .dec_dst_fmt_o(dec_dst_fmt_o), .dec_rm_o(dec_rm_o),
    .dec_rs1_o(dec_rs1_o), .dec_rs2_o(dec_rs2_o), .dec_rs3_o(dec_rs3_o), .dec_rd_o(dec_rd_o),
    .dec_fp_wb_o(dec_fp_wb_o), .dec_int_wb_o(dec_int_wb_o), .dec_load_o(dec_load_o),
    .dec_store_o(dec_store_o), .dec_move_xs_o(dec_move_xs_o), .dec_move_sx_o(dec_move_sx_o),
    .dec_fpu_o(dec_fpu_o), .dec_illegal_o(dec_illegal_o), .move_busy_o(move_busy_o)
`ifdef FP_DECODE_PERF_EN
    , .perf_decoded_o(perf_decoded_o), .perf_illegal_o(perf_illegal_o)
`endif
  );

  // Lockstep copy without double precision; only its illegal flag is scored
  fp_decode_stage #(.ENABLE_D(1'b0), .MOVE_HOLD(3), .BUF_DEPTH(2)) u_nod (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(n_ready), .instr_i(instr_i), .frm_i(frm_i), .dec_valid_o(n_valid),
    .dec_ready_i(dec_ready_i), .dec_op_o(n_op), .dec_op_mod_o(n_mod),
    .dec_src_fmt_o(n_sf), .dec_dst_fmt_o(n_df), .dec_rm_o(n_rm),
    .dec_rs1_o(n_rs1), .dec_rs2_o(n_rs2), .dec_rs3_o(n_rs3), .dec_rd_o(n_rd),
    .dec_fp_wb_o(n_fpwb), .dec_int_wb_o(n_intwb), .dec_load_o(n_ld),
    .dec_store_o(n_st), .dec_move_xs_o(n_mxs), .dec_move_sx_o(n_msx),
    .dec_fpu_o(n_fpu), .dec_illegal_o(n_ill), .move_busy_o(n_busy)
`ifdef FP_DECODE_PERF_EN
    , .perf_decoded_o(n_pd), .perf_illegal_o(n_pi)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] op, input logic m, input logic [2:0] sf,
                              input logic [2:0] df, input logic [2:0] rm, input logic [4:0] r1,
                              input logic [4:0] r2, input logic [4:0] r3, input logic [4:0] rd,
                              input logic [7:0] fl, input logic c, input logic nod);
    exp_t e;
    e.b   = {op, m, sf, df, rm, r1, r2, r3, rd, fl};
    e.chk = c;
    e.nod = nod;
    return e;
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted it
  task automatic send(input int idx);
    int n = 0;
    instr_valid_i = 1'b1;
    instr_i = v_ins[idx];
    frm_i = v_frm[idx];
    forever begin
      @(negedge clk);
      if (instr_ready_o) break;
      n++;
      if (n > 100) begin
        errors++;
        $display("FAIL send_timeout: vector %0d never accepted", idx);
        instr_valid_i = 1'b0;
        return;
      end
    end
    exp_q.push_back(v_exp[idx]);
    @(posedge clk); #1;
    instr_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1 chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compare every handshake against the scoreboard head
  initial forever begin
    @(negedge clk);
    if (!rst_i && dec_valid_o && dec_ready_i) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_bundle: rd=%0d with empty scoreboard", dec_rd_o);
      end else begin
        logic [41:0] act, msk;
        me  = exp_q.pop_front();
        act = {dec_op_o, dec_op_mod_o, dec_src_fmt_o, dec_dst_fmt_o, dec_rm_o, dec_rs1_o,
               dec_rs2_o, dec_rs3_o, dec_rd_o, dec_fp_wb_o, dec_int_wb_o, dec_load_o,
               dec_store_o, dec_move_xs_o, dec_move_sx_o, dec_fpu_o, dec_illegal_o};
        msk = me.chk ? '1 : {14'h0, 28'hFFFFFFF};
        chk("bundle", 64'(act & msk), 64'(me.b & msk));
        chk("nod_illegal", 64'({n_valid, n_ill}), 64'({1'b1, me.nod}));
      end
    end
  end

  initial begin
    v_ins[0]  = 32'h002081D3;                                          v_frm[0]  = 3'd0;
    v_exp[0]  = mk(4'd2, 0, 3'd0, 3'd0, 3'd0, 5'd1, 5'd2, 5'd0, 5'd3, 8'b1000_0010, 1, 0);
    v_ins[1]  = {5'b00010, 2'b01, 5'd5, 5'd4, 3'b111, 5'd6, 7'h53};    v_frm[1]  = 3'd1;
    v_exp[1]  = mk(4'd3, 0, 3'd1, 3'd1, 3'd1, 5'd4, 5'd5, 5'd2, 5'd6, 8'b1000_0010, 1, 1);
    v_ins[2]  = v_ins[1];                                              v_frm[2]  = 3'd5;
    v_exp[2]  = mk(4'd0, 0, 3'd0, 3'd0, 3'd0, 5'd4, 5'd5, 5'd2, 5'd6, 8'b0000_0001, 0, 1);
    v_ins[3]  = {5'd7, 2'b00, 5'd2, 5'd1, 3'b000, 5'd9, 7'h4F};        v_frm[3]  = 3'd0;
    v_exp[3]  = mk(4'd1, 1, 3'd0, 3'd0, 3'd0, 5'd1, 5'd2, 5'd7, 5'd9, 8'b1000_0010, 1, 0);
    v_ins[4]  = {5'b01011, 2'b00, 5'd1, 5'd3, 3'b000, 5'd4, 7'h53};    v_frm[4]  = 3'd0;
    v_exp[4]  = mk(4'd0, 0, 3'd0, 3'd0, 3'd0, 5'd3, 5'd1, 5'd11, 5'd4, 8'b0000_0001, 0, 1);
    v_ins[5]  = {5'b00100, 2'b00, 5'd2, 5'd1, 3'b011, 5'd3, 7'h53};    v_frm[5]  = 3'd0;
    v_exp[5]  = mk(4'd0, 0, 3'd0, 3'd0, 3'd0, 5'd1, 5'd2, 5'd4, 5'd3, 8'b0000_0001, 0, 1);
    v_ins[6]  = {12'd8, 5'd2, 3'b010, 5'd5, 7'h07};                    v_frm[6]  = 3'd0;
    v_exp[6]  = mk(4'd0, 0, 3'd0, 3'd0, 3'd2, 5'd2, 5'd8, 5'd0, 5'd5, 8'b1010_0000, 1, 0);
    v_ins[7]  = {7'd0, 5'd7, 5'd3, 3'b011, 5'd16, 7'h27};              v_frm[7]  = 3'd0;
    v_exp[7]  = mk(4'd0, 0, 3'd1, 3'd1, 3'd3, 5'd3, 5'd7, 5'd0, 5'd16, 8'b0001_0000, 1, 1);
    v_ins[8]  = {5'b11000, 2'b00, 5'd1, 5'd2, 3'b001, 5'd8, 7'h53};    v_frm[8]  = 3'd0;
    v_exp[8]  = mk(4'd11, 1, 3'd0, 3'd0, 3'd1, 5'd2, 5'd1, 5'd24, 5'd8, 8'b0100_0010, 1, 0);
    v_ins[9]  = {5'b10100, 2'b00, 5'd2, 5'd1, 3'b010, 5'd7, 7'h53};    v_frm[9]  = 3'd0;
    v_exp[9]  = mk(4'd8, 0, 3'd0, 3'd0, 3'd2, 5'd1, 5'd2, 5'd20, 5'd7, 8'b0100_0010, 1, 0);
    v_ins[10] = {5'b01000, 2'b00, 5'd1, 5'd5, 3'b000, 5'd4, 7'h53};    v_frm[10] = 3'd0;
    v_exp[10] = mk(4'd10, 0, 3'd1, 3'd0, 3'd0, 5'd5, 5'd1, 5'd8, 5'd4, 8'b1000_0010, 1, 1);
    v_ins[11] = {5'b11111, 2'b00, 5'd0, 5'd1, 3'b000, 5'd2, 7'h53};    v_frm[11] = 3'd0;
    v_exp[11] = mk(4'd0, 0, 3'd0, 3'd0, 3'd0, 5'd1, 5'd0, 5'd31, 5'd2, 8'b0000_0001, 0, 1);
    v_ins[12] = {5'd3, 2'b10, 5'd2, 5'd1, 3'b000, 5'd4, 7'h43};        v_frm[12] = 3'd0;
    v_exp[12] = mk(4'd0, 0, 3'd0, 3'd0, 3'd0, 5'd1, 5'd2, 5'd3, 5'd4, 8'b0000_0001, 0, 1);
    v_ins[13] = {5'b00001, 2'b00, 5'd2, 5'd1, 3'b101, 5'd3, 7'h53};    v_frm[13] = 3'd0;
    v_exp[13] = mk(4'd0, 0, 3'd0, 3'd0, 3'd0, 5'd1, 5'd2, 5'd1, 5'd3, 8'b0000_0001, 0, 1);
    v_ins[14] = 32'hE0008553;                                          v_frm[14] = 3'd0;
    v_exp[14] = mk(4'd0, 0, 3'd0, 3'd0, 3'd0, 5'd1, 5'd0, 5'd28, 5'd10, 8'b0100_1000, 0, 0);
    v_ins[15] = {5'b11110, 2'b00, 5'd0, 5'd2, 3'b000, 5'd1, 7'h53};    v_frm[15] = 3'd0;
    v_exp[15] = mk(4'd0, 0, 3'd0, 3'd0, 3'd0, 5'd2, 5'd0, 5'd30, 5'd1, 8'b1000_0110, 0, 0);

    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(dec_valid_o), 64'd0);
    chk("rst_ready", 64'(instr_ready_o), 64'd1);
    chk("rst_busy", 64'(move_busy_o), 64'd0);
    chk("rst_fields", 64'({dec_op_o, dec_src_fmt_o, dec_dst_fmt_o, dec_rm_o, dec_fp_wb_o, dec_illegal_o}), 64'd0);
`ifdef FP_DECODE_PERF_EN
    chk("rst_perf", 64'({perf_decoded_o, perf_illegal_o}), 64'd0);
`endif

    // Streaming decode of all vectors with the consumer always ready
    @(posedge clk); #1 dec_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) send(i);
    drain();

    // Back-pressure: two fill the skid buffer, the third waits for the first pop
    dec_ready_i = 1'b0;
    send(0);
    send(3);
    fork
      send(9);
      begin
        @(negedge clk) chk("bp_ready_full", 64'(instr_ready_o), 64'd0);
        @(negedge clk) chk("bp_head_held", 64'({dec_valid_o, dec_rd_o}), 64'({1'b1, 5'd3}));
        @(posedge clk); #1 dec_ready_i = 1'b1;
        @(negedge clk) chk("bp_ready_on_pop", 64'(instr_ready_o), 64'd1);
      end
    join
    drain();

    // Move window: single FMV, then a reload two cycles later
    @(posedge clk); #1;
    send(14);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk) chk($sformatf("busy_single_c%0d", k), 64'(move_busy_o), 64'(k <= 3));
    end
    @(posedge clk); #1;
    send(14);
    @(negedge clk) chk("busy_reload_c1", 64'(move_busy_o), 64'd1);
    @(posedge clk); #1;
    send(15);
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk) chk($sformatf("busy_reload_c%0d", k), 64'(move_busy_o), 64'(k <= 5));
    end
    drain();

    // Flush with two entries buffered and the busy window open
    @(posedge clk); #1 dec_ready_i = 1'b0;
    send(14);
    send(0);
    flush_i = 1'b1;
    @(negedge clk) chk("flush_pre_busy", 64'(move_busy_o), 64'd1);
    @(posedge clk); #1 flush_i = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(move_busy_o), 64'd0);
    chk("flush_state", 64'({dec_valid_o, instr_ready_o}), 64'({1'b0, 1'b1}));
    exp_q.delete();

    // Reset with a full buffer
    @(posedge clk); #1;
    send(0);
    send(3);
    rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst2_state", 64'({dec_valid_o, instr_ready_o, move_busy_o}), 64'({1'b0, 1'b1, 1'b0}));
`ifdef FP_DECODE_PERF_EN
    chk("rst2_perf", 64'({perf_decoded_o, perf_illegal_o}), 64'd0);
`endif
    exp_q.delete();

    @(posedge clk); #1 dec_ready_i = 1'b1;
    send(9);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
